if_fetch_stage: RTL and testbench

//  IF stage of the 5-stage MIPS pipeline: owns the PC and the IF/ID pipeline register.

---
 rtl/mips_pkg.sv | 18 +
 rtl/fetch_ctrl_fsm.sv | 44 ++++
 rtl/if_fetch_stage.sv | 116 +++++++++++
 tb/tb_if_fetch_stage.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: reset/bubble constants, fetch FSM encoding
// and a saturating increment used by the optional fetch statistics.
package mips_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_ctrl_fsm.sv
// Fetch controller: owns the BOOT/FETCH/DISCARD state, drives ImemReq and decides
// whether the beat returned this cycle is accepted or dropped as stale.
module fetch_ctrl_fsm
    import mips_pkg::*;
(
    input  logic Clk,
    input  logic Rst_n,
    input  logic Flush,
    input  logic ImemReady,
    output logic ImemReq,
    output logic Accept
);

    fetch_state_e state_q, state_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state_q <= BOOT;
        else        state_q <= state_d;
    end

    // NOTE: every output gets a default before the case so no path can leave one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        ImemReq = 1'b0;
        Accept  = 1'b0;
        unique case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
                ImemReq = 1'b1;
                Accept  = ImemReady && !Flush;
                // A flush with the request still in flight leaves one stale beat owed.
                if (Flush && !ImemReady) state_d = DISCARD;
            end
            DISCARD: begin
                if (ImemReady && !Flush) state_d = FETCH;
            end
            default: state_d = BOOT;
        endcase
    end

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS IF stage: PC, instruction-memory handshake and the IF/ID pipeline register.
// Define FETCH_STATS_EN to add saturating stall / imem-wait / flush counters.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = mips_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        PCWrite,
    input  logic        IFIDWrite,
    input  logic        Flush,
    input  logic [31:0] BranchTarget,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemReady,
    input  logic [31:0] ImemRdata,
    output logic [31:0] PC,
    output logic [31:0] IFID_Instr,
    output logic [31:0] IFID_PCPlus4,
    output logic        IFID_Valid
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] StallCycles,
    output logic [31:0] ImemWaitCycles,
    output logic [31:0] FlushCount
`endif
);

    logic        accept;
    logic        advance;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcplus4_q, pcplus4_d;
    logic        valid_q, valid_d;

    fetch_ctrl_fsm u_ctrl (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Flush     (Flush),
        .ImemReady (ImemReady),
        .ImemReq   (ImemReq),
        .Accept    (accept)
    );

    assign pc_plus4 = pc_q + 32'd4;
    assign advance  = accept && PCWrite;

    always_comb begin
        pc_d = pc_q;
        if (Flush)        pc_d = BranchTarget;
        else if (advance) pc_d = pc_plus4;
    end

    always_comb begin
        instr_d   = instr_q;
        pcplus4_d = pcplus4_q;
        valid_d   = valid_q;
        if (Flush) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (IFIDWrite) begin
            if (advance) begin
                instr_d   = ImemRdata;
                pcplus4_d = pc_plus4;
                valid_d   = 1'b1;
            end else begin
                // Nothing usable this cycle: hand decode a bubble.
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pc_q      <= RESET_PC;
            instr_q   <= NOP_INSTR;
            pcplus4_q <= 32'd0;
            valid_q   <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            pcplus4_q <= pcplus4_d;
            valid_q   <= valid_d;
        end
    end

    assign ImemAddr     = pc_q;
    assign PC           = pc_q;
    assign IFID_Instr   = instr_q;
    assign IFID_PCPlus4 = pcplus4_q;
    assign IFID_Valid   = valid_q;

`ifdef FETCH_STATS_EN
    logic [31:0] stall_q, wait_q, flush_q;

    // ImemReq is high exactly while the controller is in FETCH.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stall_q <= 32'd0;
            wait_q  <= 32'd0;
            flush_q <= 32'd0;
        end else begin
            if (ImemReq && !PCWrite)   stall_q <= mips_pkg::sat_inc(stall_q);
            if (ImemReq && !ImemReady) wait_q  <= mips_pkg::sat_inc(wait_q);
            if (Flush)                 flush_q <= mips_pkg::sat_inc(flush_q);
        end
    end

    assign StallCycles    = stall_q;
    assign ImemWaitCycles = wait_q;
    assign FlushCount     = flush_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus randomized traffic,
// checked against a behavioural model and a scoreboard of accepted instructions.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        PCWrite, IFIDWrite, Flush;
    logic [31:0] BranchTarget;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemReady;
    logic [31:0] ImemRdata;
    logic [31:0] PC, IFID_Instr, IFID_PCPlus4;
    logic        IFID_Valid;
`ifdef FETCH_STATS_EN
    logic [31:0] StallCycles, ImemWaitCycles, FlushCount;
`endif

    if_fetch_stage dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .PCWrite      (PCWrite),
        .IFIDWrite    (IFIDWrite),
        .Flush        (Flush),
        .BranchTarget (BranchTarget),
        .ImemReq      (ImemReq),
        .ImemAddr     (ImemAddr),
        .ImemReady    (ImemReady),
        .ImemRdata    (ImemRdata),
        .PC           (PC),
        .IFID_Instr   (IFID_Instr),
        .IFID_PCPlus4 (IFID_PCPlus4),
        .IFID_Valid   (IFID_Valid)
`ifdef FETCH_STATS_EN
        ,
        .StallCycles    (StallCycles),
        .ImemWaitCycles (ImemWaitCycles),
        .FlushCount     (FlushCount)
`endif
    );

    always #5 Clk = ~Clk;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction memory model ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h2008_0001;
            32'h0000_0004: return 32'h2009_0002;
            default:       return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
        endcase
    endfunction

    bit          mem_busy = 0;
    int          mem_cnt = 0;
    bit          lat_rand = 0;
    int          lat_fixed = 0;
    bit          ovr_en = 0;
    logic [31:0] ovr_data = 32'h0;

    // One request in flight at a time; a reply completes the oldest request.
    task automatic mem_step();
        if (!mem_busy && ImemReq) begin
            mem_busy = 1;
            mem_cnt  = lat_rand ? int'($urandom_range(0, 2)) : lat_fixed;
        end
        ImemReady = 1'b0;
        ImemRdata = $urandom;
        if (mem_busy) begin
            if (mem_cnt == 0) begin
                ImemReady = 1'b1;
                ImemRdata = ovr_en ? ovr_data : mem_word(ImemAddr);
                ovr_en    = 0;
                mem_busy  = 0;
            end else begin
                mem_cnt--;
            end
        end
    endtask

    task automatic drive(input logic pw, input logic iw, input logic fl, input logic [31:0] bt);
        @(negedge Clk);
        mem_step();
        // A flush coinciding with the stale beat's return would strand the fetch unit.
        if (fl && ImemReady && !ImemReq) fl = 1'b0;
        PCWrite      = pw;
        IFIDWrite    = iw;
        Flush        = fl;
        BranchTarget = bt;
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pcplus4;
    } beat_t;

    beat_t       sb_q[$];
    logic [31:0] m_pc, m_instr, m_p4;
    bit          m_valid, m_boot, m_discard, m_last_iw;
    int          m_stall, m_wait, m_flush;

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            m_pc = 32'h0; m_instr = NOP; m_p4 = 32'h0; m_valid = 0;
            m_boot = 1; m_discard = 0; m_last_iw = 0;
            m_stall = 0; m_wait = 0; m_flush = 0;
            sb_q.delete();
        end else begin
            bit fetching, take;
            fetching = !m_boot && !m_discard;
            take     = fetching && ImemReady && !Flush && PCWrite;
            if (fetching && !PCWrite)   m_stall++;
            if (fetching && !ImemReady) m_wait++;
            if (Flush)                  m_flush++;
            m_last_iw = IFIDWrite;
            if (Flush) begin
                m_instr = NOP; m_valid = 0;
            end else if (IFIDWrite) begin
                if (take) begin
                    m_instr = ImemRdata; m_p4 = m_pc + 32'd4; m_valid = 1;
                    sb_q.push_back('{ImemRdata, m_pc + 32'd4});
                end else begin
                    m_instr = NOP; m_valid = 0;
                end
            end
            if (Flush)     m_pc = BranchTarget;
            else if (take) m_pc = m_pc + 32'd4;
            if (m_boot)          m_boot = 0;
            else if (!m_discard) m_discard = Flush && !ImemReady;
            else if (!Flush && ImemReady) m_discard = 0;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int idle = 0;
    initial begin
        forever begin
            @(posedge Clk);
            #1;
            check("pc", PC, m_pc);
            check("imem_addr", ImemAddr, m_pc);
            check("imem_req", 32'(ImemReq), 32'(!m_boot && !m_discard));
            check("ifid_valid", 32'(IFID_Valid), 32'(m_valid));
            check("ifid_instr", IFID_Instr, m_instr);
            check("ifid_pcplus4", IFID_PCPlus4, m_p4);
`ifdef FETCH_STATS_EN
            check("stall_cycles", StallCycles, 32'(m_stall));
            check("imem_wait_cycles", ImemWaitCycles, 32'(m_wait));
            check("flush_count", FlushCount, 32'(m_flush));
`endif
            idle++;
            if (Rst_n && IFID_Valid && m_last_iw) begin
                if (sb_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL sb_underflow: got instr %h with no expected entry", IFID_Instr);
                end else begin
                    beat_t b;
                    b = sb_q.pop_front();
                    check("sb_instr", IFID_Instr, b.instr);
                    check("sb_pcplus4", IFID_PCPlus4, b.pcplus4);
                    idle = 0;
                end
            end
            if (idle > 300) begin
                tests_run++;
                tests_failed++;
                $display("FAIL fetch_timeout: got %0d idle cycles expected at most 300", idle);
                idle = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        PCWrite = 1'b1; IFIDWrite = 1'b1; Flush = 1'b0; BranchTarget = 32'h0;
        ImemReady = 1'b0; ImemRdata = 32'h0;

        // T1: reset
        Rst_n = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_pc", PC, 32'h0);
        check("rst_valid", 32'(IFID_Valid), 32'h0);
        check("rst_req", 32'(ImemReq), 32'h0);
        Rst_n = 1'b1;
        #1 check("boot_req", 32'(ImemReq), 32'h0);
        @(posedge Clk); #1 check("fetch_req", 32'(ImemReq), 32'h1);

        // T2: streaming
        drive(1, 1, 0, 0);
        @(posedge Clk); #1;
        check("t2_instr0", IFID_Instr, 32'h2008_0001);
        check("t2_p4_0", IFID_PCPlus4, 32'h4);
        drive(1, 1, 0, 0);
        @(posedge Clk); #1;
        check("t2_instr1", IFID_Instr, 32'h2009_0002);
        check("t2_p4_1", IFID_PCPlus4, 32'h8);

        // T3: load-use stall at PC=8
        drive(0, 0, 0, 0);
        @(posedge Clk); #1;
        check("t3_pc_hold", PC, 32'h8);
        check("t3_instr_hold", IFID_Instr, 32'h2009_0002);
        drive(1, 1, 0, 0);
        @(posedge Clk); #1;
        check("t3_refetch", IFID_Instr, mem_word(32'h8));
        check("t3_refetch_p4", IFID_PCPlus4, 32'hC);

        // T4: flush with ready, IFIDWrite low
        drive(1, 0, 1, 32'h40);
        @(posedge Clk); #1;
        check("t4_pc", PC, 32'h40);
        check("t4_valid", 32'(IFID_Valid), 32'h0);

        // T5: flush while waiting; stale beat must be dropped
        lat_fixed = 3;
        drive(1, 1, 0, 0);
        drive(1, 1, 1, 32'h80);
        lat_fixed = 0;
        ovr_en = 1; ovr_data = 32'hDEAD_BEEF;
        drive(1, 1, 0, 0);
        drive(1, 1, 0, 0);
        @(posedge Clk); #1;
        check("t5_dropped", 32'(IFID_Valid), 32'h0);
        drive(1, 1, 0, 0);
        @(posedge Clk); #1;
        check("t5_next_instr", IFID_Instr, mem_word(32'h80));
        check("t5_next_p4", IFID_PCPlus4, 32'h84);

        // PC wrap and unaligned redirect
        drive(1, 1, 1, 32'hFFFF_FFFC);
        drive(1, 1, 0, 0);
        @(posedge Clk); #1;
        check("wrap_pc", PC, 32'h0);
        check("wrap_p4", IFID_PCPlus4, 32'h0);
        drive(1, 1, 1, 32'h0000_0102);
        @(posedge Clk); #1;
        check("unaligned_pc", PC, 32'h0000_0102);

        // Reset in the middle of an outstanding fetch
        lat_fixed = 2;
        drive(1, 1, 0, 0);
        @(posedge Clk); #2;
        Rst_n = 1'b0;
        mem_busy = 0;
        ImemReady = 1'b0;
        #1 check("midrst_pc", PC, 32'h0);
        @(negedge Clk);
        Rst_n = 1'b1;
        lat_fixed = 0;

        // Randomized traffic
        lat_rand = 1;
        for (int i = 0; i < 2000; i++) begin
            logic        pw, iw, fl;
            logic [31:0] bt;
            pw = ($urandom % 8) != 0;
            iw = (($urandom % 4) != 0) ? pw : 1'($urandom);
            fl = ($urandom % 12) == 0;
            bt = $urandom;
            if (($urandom % 4) != 0) bt[1:0] = 2'b00;
            drive(pw, iw, fl, bt);
        end
        drive(1, 1, 0, 0);
        @(posedge Clk); #2;
        check("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
